// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter that shares one integer ALU between NREQ issue sources.
// Requests are accepted into an operand stage (stage 1), evaluated by a
// combinational ALU, and registered into a result stage that drives a single
// tagged valid/ready output channel. A synchronous flush kills everything in
// flight without disturbing the round-robin pointer.

module alu_issue_arbiter #(
  parameter int NREQ = 3,
  parameter int TAGW = 6,
  parameter int SRCW = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,

  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_in1,
  input  logic [32*NREQ-1:0]   req_in2,
  input  logic [32*NREQ-1:0]   req_imm,
  input  logic [NREQ-1:0]      req_alusrc,
  input  logic [2*NREQ-1:0]    req_aluop,
  input  logic [10*NREQ-1:0]   req_funct,
  input  logic [TAGW*NREQ-1:0] req_tag,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_zero,
  output logic [TAGW-1:0]      out_tag,
  output logic [SRCW-1:0]      out_src
);

  localparam logic [SRCW-1:0] LAST_IDX = SRCW'(NREQ - 1);

  // ALU op-class encodings
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;

  // funct3 encodings decoded for register/immediate op classes
  localparam logic [2:0] F3_ADDSUB = 3'd0;
  localparam logic [2:0] F3_OR     = 3'd6;
  localparam logic [2:0] F3_AND    = 3'd7;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [SRCW-1:0] rr_ptr;

  logic [NREQ-1:0] grant;
  logic [SRCW-1:0] grant_idx;
  logic            grant_any;

  logic            out_adv;
  logic            s1_free;
  logic            accept;

  logic [31:0]     sel_in1;
  logic [31:0]     sel_opb;
  logic [1:0]      sel_aluop;
  logic [9:0]      sel_funct;
  logic [TAGW-1:0] sel_tag;

  logic            s1_valid;
  logic [31:0]     s1_a;
  logic [31:0]     s1_b;
  logic [1:0]      s1_aluop;
  logic [9:0]      s1_funct;
  logic [TAGW-1:0] s1_tag;
  logic [SRCW-1:0] s1_src;

  logic [31:0]     alu_result;

  // ---------------------------------------------------------------------------
  // ALU evaluation: 32-bit wrap-around arithmetic; any funct3 other than
  // add/sub, OR and AND (including SLT) yields 0.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] alu_eval(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [1:0]  aluop,
    input logic [9:0]  funct
  );
    logic [31:0] r;
    r = '0;
    case (aluop)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: begin
        case (funct[2:0])
          F3_ADDSUB: r = (funct[9:3] == 7'd0) ? (a + b) : (a - b);
          F3_OR:     r = a | b;
          F3_AND:    r = a & b;
          default:   r = '0;
        endcase
      end
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin grant: the valid requester at the smallest distance from the
  // pointer (modulo NREQ) wins. Depends on req_valid and rr_ptr only, so no
  // ready signal can feed back into the grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a value unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[i] &&
            ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NREQ))) begin
          grant_any = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = SRCW'(i);
        end
      end
    end
  end

  // Pipeline flow control: output advances when empty or consumed; stage 1
  // can take a new op when empty or when it is moving to the output stage.
  always_comb begin
    out_adv   = ~out_valid | out_ready;
    s1_free   = ~s1_valid | out_adv;
    req_ready = grant & {NREQ{s1_free & ~flush & reset_n}};
    accept    = grant_any & s1_free & ~flush & reset_n;
  end

  // Payload mux for the granted requester; operand B selects imm or register.
  always_comb begin
    sel_in1   = '0;
    sel_opb   = '0;
    sel_aluop = '0;
    sel_funct = '0;
    sel_tag   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_in1   = req_in1[32*i +: 32];
        sel_opb   = req_alusrc[i] ? req_imm[32*i +: 32] : req_in2[32*i +: 32];
        sel_aluop = req_aluop[2*i +: 2];
        sel_funct = req_funct[10*i +: 10];
        sel_tag   = req_tag[TAGW*i +: TAGW];
      end
    end
  end

  // Round-robin pointer moves just past the winner on every accept.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of the order blocks are evaluated.
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  // Stage-1 occupancy: flush wins, then a new accept, then drain to output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (out_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage-1 payload capture on accept.
  always_ff @(posedge clk) begin
    // NOTE: payload flops carry no reset; s1_valid qualifies them, so their
    // power-up contents are never observed.
    if (accept) begin
      s1_a     <= sel_in1;
      s1_b     <= sel_opb;
      s1_aluop <= sel_aluop;
      s1_funct <= sel_funct;
      s1_tag   <= sel_tag;
      s1_src   <= grant_idx;
    end
  end

  // Combinational ALU on the stage-1 operands.
  always_comb begin
    alu_result = alu_eval(s1_a, s1_b, s1_aluop, s1_funct);
  end

  // Result stage: loads when the consumer can take a new value, holds on
  // backpressure, and is emptied by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_tag    <= '0;
      out_src    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= alu_result;
        out_zero   <= (alu_result == 32'd0);
        out_tag    <= s1_tag;
        out_src    <= s1_src;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: a negedge monitor predicts the
// round-robin winner, pushes the expected result on every accept, and compares
// against the output channel whenever out_valid is seen.

module tb_alu_issue_arbiter;

  localparam int NREQ = 3;
  localparam int TAGW = 6;
  localparam int SRCW = 2;

  typedef struct {
    logic [31:0]     a;
    logic [31:0]     b;
    logic [31:0]     imm;
    logic            alusrc;
    logic [1:0]      aluop;
    logic [9:0]      funct;
    logic [TAGW-1:0] tag;
  } op_t;

  typedef struct {
    logic [31:0]     res;
    logic            zero;
    logic [TAGW-1:0] tag;
    int              src;
    int              acc_cyc;
    bit              chk_lat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 flush = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_in1 = '0;
  logic [32*NREQ-1:0]   req_in2 = '0;
  logic [32*NREQ-1:0]   req_imm = '0;
  logic [NREQ-1:0]      req_alusrc = '0;
  logic [2*NREQ-1:0]    req_aluop = '0;
  logic [10*NREQ-1:0]   req_funct = '0;
  logic [TAGW*NREQ-1:0] req_tag = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [31:0]          out_result;
  logic                 out_zero;
  logic [TAGW-1:0]      out_tag;
  logic [SRCW-1:0]      out_src;

  alu_issue_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .SRCW(SRCW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_imm   (req_imm),
    .req_alusrc(req_alusrc),
    .req_aluop (req_aluop),
    .req_funct (req_funct),
    .req_tag   (req_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .out_tag   (out_tag),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_out = 0;
  int   ptr_m = 0;
  int   tag_ctr = 32;
  int   last_tag = -1;
  bit   lat_mode = 0;
  bit   rearm = 0;
  bit   rand_mode = 0;
  op_t  cur [NREQ];
  bit   vld [NREQ];
  bit   acc_flag [NREQ];
  exp_t sb [$];
  int   log_idx [$];
  int   log_cyc [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference ALU written directly from the operation table.
  function automatic logic [31:0] ref_alu(input op_t op);
    logic [31:0] b;
    b = op.alusrc ? op.imm : op.b;
    if (op.aluop == 2'd0) return op.a + b;
    if (op.aluop == 2'd1) return op.a - b;
    case (op.funct[2:0])
      3'd0:    return (op.funct[9:3] == 0) ? op.a + b : op.a - b;
      3'd6:    return op.a | b;
      3'd7:    return op.a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    logic [2:0] f3;
    logic [6:0] f7;
    o.a      = $urandom;
    o.b      = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
    o.imm    = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
    o.alusrc = 1'($urandom_range(0, 1));
    o.aluop  = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 4))
      0: f3 = 3'd0;
      1: f3 = 3'd2;
      2: f3 = 3'd6;
      3: f3 = 3'd7;
      default: f3 = 3'($urandom);
    endcase
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    o.funct = {f7, f3};
    o.tag   = TAGW'(tag_ctr);
    tag_ctr++;
    return o;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]              = vld[i];
      req_in1[32*i +: 32]       = cur[i].a;
      req_in2[32*i +: 32]       = cur[i].b;
      req_imm[32*i +: 32]       = cur[i].imm;
      req_alusrc[i]             = cur[i].alusrc;
      req_aluop[2*i +: 2]       = cur[i].aluop;
      req_funct[10*i +: 10]     = cur[i].funct;
      req_tag[TAGW*i +: TAGW]   = cur[i].tag;
    end
  endtask

  // One clock: retire accepted requests (new payload or drop valid), then drive.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 0;
        if (rearm && (!rand_mode || $urandom_range(0, 1) == 0)) cur[i] = rand_op();
        else vld[i] = 0;
      end else if (rand_mode && !vld[i] && $urandom_range(0, 1) == 0) begin
        cur[i] = rand_op();
        vld[i] = 1;
      end
    end
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
    end
    drive();
  endtask

  function automatic int busy_count();
    int n;
    n = sb.size();
    for (int i = 0; i < NREQ; i++) n += int'(vld[i]);
    return n;
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (busy_count() == 0 && !out_valid) break;
      step();
    end
    check("drain_idle", 32'(busy_count()), 32'd0);
  endtask

  // Issue one op on requester i and check the returned result against constants.
  task automatic issue_expect(input int i, input op_t op, input logic [31:0] res,
                              input logic zero);
    cur[i] = op;
    vld[i] = 1;
    drive();
    for (int k = 0; k < 20 && vld[i]; k++) step();
    for (int k = 0; k < 10; k++) begin
      if (out_valid && out_tag == op.tag) break;
      step();
    end
    check("dir_valid", 32'(out_valid), 32'd1);
    check("dir_result", out_result, res);
    check("dir_zero", 32'(out_zero), 32'(zero));
    check("dir_tag", 32'(out_tag), 32'(op.tag));
    check("dir_src", 32'(out_src), 32'(i));
    step();
  endtask

  // Monitor: compare presented outputs with the scoreboard, predict grants,
  // push expectations on accept.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      ptr_m = 0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check("out_result", out_result, sb[0].res);
          check("out_zero", 32'(out_zero), 32'(sb[0].zero));
          check("out_tag", 32'(out_tag), 32'(sb[0].tag));
          check("out_src", 32'(out_src), 32'(sb[0].src));
          if (out_ready) begin
            if (sb[0].chk_lat) check("latency", 32'(cyc - sb[0].acc_cyc), 32'd2);
            last_tag = int'(sb[0].tag);
            n_out++;
            void'(sb.pop_front());
          end
        end
      end
      if (flush) begin
        sb.delete();
        check("no_accept_in_flush", 32'(req_ready), 32'd0);
      end else begin
        logic [NREQ-1:0] acc;
        acc = req_valid & req_ready;
        if (acc != '0) begin
          int g;
          int g_exp;
          exp_t e;
          g = -1;
          g_exp = -1;
          n_acc++;
          if ($countones(acc) != 1) check("grant_onehot", 32'($countones(acc)), 32'd1);
          for (int i = NREQ - 1; i >= 0; i--) if (acc[i]) g = i;
          for (int k = 0; k < NREQ; k++)
            if (g_exp < 0 && vld[(ptr_m + k) % NREQ]) g_exp = (ptr_m + k) % NREQ;
          check("rr_grant", 32'(g), 32'(g_exp));
          ptr_m = (g + 1) % NREQ;
          e.res     = ref_alu(cur[g]);
          e.zero    = (e.res == 0);
          e.tag     = cur[g].tag;
          e.src     = g;
          e.acc_cyc = cyc;
          e.chk_lat = lat_mode;
          sb.push_back(e);
          for (int i = 0; i < NREQ; i++) if (acc[i]) acc_flag[i] = 1;
          log_idx.push_back(g);
          log_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    op_t o;
    int  a0;
    int  o0;

    // Reset state, with all requesters already asserting valid.
    for (int i = 0; i < NREQ; i++) begin
      cur[i] = rand_op();
      vld[i] = 1;
      acc_flag[i] = 0;
    end
    rearm = 1;
    drive();
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);

    // All three held valid from reset: 0,1,2,0,1,2 on consecutive cycles.
    lat_mode  = 1;
    out_ready = 1;
    reset_n   = 1;
    log_idx.delete();
    log_cyc.delete();
    repeat (6) step();
    check("rr_log_len", 32'(log_idx.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < log_idx.size(); k++) begin
      check("rr_order", 32'(log_idx[k]), 32'(k % NREQ));
      check("rr_back_to_back", 32'(log_cyc[k] - log_cyc[0]), 32'(k));
    end
    rearm = 0;
    wait_idle();

    // Directed ALU operations.
    o = '{a: 5, b: 7, imm: 0, alusrc: 0, aluop: 0, funct: 0, tag: 6'h11};
    issue_expect(0, o, 32'd12, 1'b0);
    o = '{a: 9, b: 123, imm: 9, alusrc: 1, aluop: 1, funct: 0, tag: 6'h12};
    issue_expect(1, o, 32'd0, 1'b1);
    o = '{a: 3, b: 5, imm: 0, alusrc: 0, aluop: 2, funct: {7'h20, 3'd0}, tag: 6'h13};
    issue_expect(2, o, 32'hFFFF_FFFE, 1'b0);
    o = '{a: 32'hF0F0, b: 32'hFF00, imm: 0, alusrc: 0, aluop: 2, funct: {7'h00, 3'd7}, tag: 6'h14};
    issue_expect(2, o, 32'h0000_F000, 1'b0);
    o = '{a: 32'hF0F0, b: 32'h1, imm: 32'hFF00, alusrc: 1, aluop: 3, funct: {7'h00, 3'd6}, tag: 6'h15};
    issue_expect(0, o, 32'h0000_FFF0, 1'b0);
    o = '{a: 1, b: 2, imm: 0, alusrc: 0, aluop: 2, funct: {7'h00, 3'd2}, tag: 6'h16};
    issue_expect(1, o, 32'd0, 1'b1);
    o = '{a: 3, b: 5, imm: 0, alusrc: 0, aluop: 3, funct: {7'h00, 3'd0}, tag: 6'h17};
    issue_expect(2, o, 32'd8, 1'b0);
    o = '{a: 32'hFFFF_FFFF, b: 1, imm: 0, alusrc: 0, aluop: 0, funct: 0, tag: 6'h18};
    issue_expect(0, o, 32'd0, 1'b1);

    // Backpressure: 3 pending, consumer stalled 4 cycles -> 2 accepts.
    lat_mode  = 0;
    out_ready = 0;
    for (int i = 0; i < NREQ; i++) begin
      cur[i] = rand_op();
      vld[i] = 1;
    end
    drive();
    a0 = n_acc;
    o0 = n_out;
    repeat (4) step();
    check("bp_accepts", 32'(n_acc - a0), 32'd2);
    check("bp_ready_idle", 32'(req_ready), 32'd0);
    out_ready = 1;
    drive();
    wait_idle();
    check("bp_outputs", 32'(n_out - o0), 32'd3);

    // Flush with two ops in flight and requester 0 waiting.
    out_ready = 0;
    cur[1] = rand_op();
    cur[2] = rand_op();
    vld[1] = 1;
    vld[2] = 1;
    drive();
    for (int k = 0; k < 10 && (vld[1] || vld[2]); k++) step();
    check("fl_two_in_flight", 32'(sb.size()), 32'd2);
    cur[0] = rand_op();
    vld[0] = 1;
    flush  = 1;
    drive();
    @(negedge clk);
    #1;
    check("fl_ready0_low", 32'(req_ready[0]), 32'd0);
    step();
    check("fl_out_valid", 32'(out_valid), 32'd0);
    flush = 0;
    out_ready = 1;
    o0 = n_out;
    drive();
    wait_idle();
    check("fl_one_output", 32'(n_out - o0), 32'd1);
    check("fl_survivor_tag", 32'(last_tag), 32'(cur[0].tag));

    // Asynchronous reset mid-stream.
    rearm = 1;
    for (int i = 0; i < NREQ; i++) begin
      cur[i] = rand_op();
      vld[i] = 1;
    end
    drive();
    repeat (4) step();
    #1;
    reset_n = 0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_req_ready", 32'(req_ready), 32'd0);
    step();
    reset_n = 1;
    log_idx.delete();
    log_cyc.delete();
    step();
    check("ar_first_grant", 32'(log_idx.size() > 0 ? log_idx[0] : -1), 32'd0);
    rearm = 0;
    wait_idle();

    // Randomized traffic with random backpressure and occasional flush.
    rand_mode = 1;
    rearm = 1;
    repeat (600) step();
    rand_mode = 0;
    rearm = 0;
    flush = 0;
    out_ready = 1;
    drive();
    wait_idle();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
Shares the single execute-stage integer ALU between NREQ issue sources (e.g. integer issue queue, branch unit, address-generation) in the I2OI core.
- Round-robin arbitration with valid/ready handshakes on every requester.
- Two-stage registered pipeline: operand stage, then result stage.
- Tagged results returned on one valid/ready output channel, with a synchronous flush for mispredict recovery.

Parameters:
NREQ, 3, number of requesters (2..4)
TAGW, 6, width of the per-operation tag carried to the result
SRCW, 2, width of the requester-index field; must satisfy 2^SRCW >= NREQ

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all in-flight operations
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept
req_in1  in  32*NREQ  operand A, requester i at [32*i+:32]
req_in2  in  32*NREQ  operand B register value
req_imm  in  32*NREQ  immediate
req_alusrc  in  NREQ  1 = use imm as operand B
req_aluop  in  2*NREQ  ALU op class
req_funct  in  10*NREQ  {funct7[6:0], funct3[2:0]}
req_tag  in  TAGW*NREQ  opaque tag
out_valid  out  1  result valid
out_ready  in  1  consumer accept
out_result  out  32  ALU result
out_zero  out  1  result == 0
out_tag  out  TAGW  tag of the result
out_src  out  SRCW  index of the requester that issued the result

Behaviour:
- Reset (asynchronous, reset_n low):
  - s1_valid = 0, out_valid = 0, out_result/out_zero/out_tag/out_src = 0.
  - RR pointer = 0, so requester 0 has top priority.
  - req_ready = 0 while reset_n is low.
  - Reset asserted mid-operation discards all in-flight operations; nothing is emitted after release.
- Handshake rules:
  - Transfer happens when valid & ready are both high on a rising edge.
  - A requester holds valid and payload stable until accepted.
  - The consumer sees out_* stable while out_valid & ~out_ready.
- Arbitration:
  - grant is one-hot, computed from req_valid and the RR pointer only (never from any ready, so no combinational loop).
  - Search order is ptr, ptr+1, ..., wrapping modulo NREQ.
- Pipeline control:
  - out_adv = ~out_valid | out_ready
  - s1_free = ~s1_valid | out_adv
  - req_ready[i] = grant[i] & s1_free & ~flush & reset_n
- Accept: on accept of requester g:
  - Stage 1 latches {in1, alusrc ? imm : in2, aluop, funct, tag, g}; s1_valid = 1.
  - RR pointer = (g+1) mod NREQ.
  - The pointer is unchanged when no accept occurs.
- Result stage:
  - When s1_valid & out_adv, the output registers load the ALU result from stage 1; out_valid = 1.
  - If out_adv is high and stage 1 is empty, out_valid = 0.
- Latency and throughput:
  - Latency is 2 cycles: accepted at edge T, out_valid high after edge T+1.
  - With out_ready held high, throughput is 1 op/cycle.
- Backpressure: out_valid & ~out_ready holds the output registers, and stage 1 holds if full. At most 2 ops are in flight; no drop, no reorder.
- Flush:
  - Clears s1_valid and out_valid at the next edge; no accepts that cycle.
  - RR pointer is unaffected.
  - Flush takes priority over simultaneous accept/advance.
- ALU function: combinational, full sensitivity, 32-bit wrap-around arithmetic.
  - aluop 0: A+B
  - aluop 1: A-B
  - aluop 2/3, decoded on funct3:
    - funct3 0: funct7==0 gives A+B, else A-B
    - funct3 6: A|B
    - funct3 7: A&B
    - funct3 2 (SLT) and all others: 0
  - out_zero = (result == 0), registered with out_result.
- Results are returned in acceptance order.

Test Plan:
- Req0 only: in1=5, in2=7, aluop=0, tag=0x11; out_ready=1 -> out_valid 2 cycles after accept, out_result=12, out_zero=0, out_tag=0x11, out_src=0.
- Req1: in1=9, imm=9, alusrc=1, aluop=1 -> out_result=0, out_zero=1, out_src=1. Req2: aluop=2, funct={7'h20,3'd0}, in1=3, in2=5 -> out_result=0xFFFFFFFE. Also check funct3=7 (AND), funct3=6 (OR), funct3=2 (-> 0).
- All three requesters held valid from reset -> accept order 0,1,2,0,1,2 on consecutive cycles; out_src follows the same order.
- out_ready low for 4 cycles with 3 requests pending -> exactly 2 accepts, then req_ready all 0; after release, results drain in order with no loss or duplication.
- flush pulsed with 2 ops in flight and req0 valid -> out_valid 0 next cycle, req_ready[0]=0 during flush, req0 accepted the following cycle and its result is the only one emitted.
- reset_n pulsed low asynchronously mid-stream -> out_valid and req_ready drop immediately; after release, requester 0 is granted first and no pre-reset result appears.
